// File: rtl/instr_fetch_pkg.sv
// Shared fetch definitions: FSM state encoding, instruction field ranges, default reset PC
// and opcode constants that the decoder also uses.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    IF_REQ   = 2'd0,
    IF_HOLD  = 2'd1,
    IF_FLUSH = 2'd2
  } if_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam int SH_HI = 10;
  localparam int SH_LO = 6;
  localparam int FN_HI = 5;
  localparam int FN_LO = 0;

  localparam logic [5:0] R_FORMAT = 6'h00;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction memory req/ack port plus the decoded-instruction
// valid/ready port towards decode. The master side is the fetch unit.
interface instr_fetch_if #(
  parameter int PC_W = 32
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  logic            ir_valid;
  logic            ir_ready;
  logic [31:0]     instr;
  logic [5:0]      opcode;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [4:0]      rd;
  logic [4:0]      shamt;
  logic [5:0]      func;
  logic [PC_W-1:0] ir_pc;

  modport master (
    output imem_req, imem_addr, ir_valid, instr, opcode, rs, rt, rd, shamt, func, ir_pc,
    input  imem_ack, imem_rdata, ir_ready
  );

  modport slave (
    input  imem_req, imem_addr, ir_valid, instr, opcode, rs, rt, rd, shamt, func, ir_pc,
    output imem_ack, imem_rdata, ir_ready
  );
endinterface

// File: rtl/instr_fetch_pc_unit.sv
// Program counter: holds the fetch PC, advances by 4 (wrapping) or loads a
// word-aligned redirect target. pc_next exposes the value the register will take.
module instr_fetch_pc_unit #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            inc,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next
);

  localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(3));

  logic [PC_W-1:0] pc_q;

  // A redirect always wins over the sequential increment.
  always_comb begin
    pc_next = pc_q;
    if (redirect) begin
      pc_next = redirect_pc & ALIGN_MASK;
    end else if (inc) begin
      pc_next = pc_q + PC_W'(4);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: req/ack instruction-memory reads, instruction register and
// field slicing towards decode. Optional IFETCH_PERF_EN adds fetch/stall counters.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic            clock,
  input  logic            reset,
  instr_fetch_if.master   bus,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     stall_cnt
`endif
);

  if_state_e       state, state_n;
  logic            req_q, req_n;
  logic [PC_W-1:0] addr_q, addr_n;
  logic            valid_q, valid_n;
  logic            load_ir;
  logic            inc;
  logic [31:0]     instr_q;
  logic [PC_W-1:0] ir_pc_q;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;

  instr_fetch_pc_unit #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clock       (clock),
    .reset       (reset),
    .inc         (inc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .pc_next     (pc_next)
  );

  // REQ with req_q low is the one-cycle gap after reset or after a discarded ack;
  // the request is raised there using pc_next so a same-cycle redirect is honoured.
  always_comb begin
    state_n = state;
    req_n   = req_q;
    addr_n  = addr_q;
    valid_n = valid_q;
    load_ir = 1'b0;
    inc     = 1'b0;
    unique case (state)
      IF_REQ: begin
        if (!req_q) begin
          req_n  = 1'b1;
          addr_n = pc_next;
        end else if (bus.imem_ack) begin
          req_n = 1'b0;
          if (!redirect) begin
            inc     = 1'b1;
            load_ir = 1'b1;
            valid_n = 1'b1;
            state_n = IF_HOLD;
          end
        end else if (redirect) begin
          state_n = IF_FLUSH;
        end
      end
      IF_FLUSH: begin
        if (bus.imem_ack) begin
          req_n   = 1'b0;
          state_n = IF_REQ;
        end
      end
      IF_HOLD: begin
        if (redirect || bus.ir_ready) begin
          valid_n = 1'b0;
          req_n   = 1'b1;
          addr_n  = pc_next;
          state_n = IF_REQ;
        end
      end
      default: begin
        req_n   = 1'b0;
        valid_n = 1'b0;
        state_n = IF_REQ;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IF_REQ;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      req_q   <= req_n;
      addr_q  <= addr_n;
      valid_q <= valid_n;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr_q <= '0;
      ir_pc_q <= '0;
    end else if (load_ir) begin
      instr_q <= bus.imem_rdata;
      ir_pc_q <= pc;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.ir_valid  = valid_q;
  assign bus.instr     = instr_q;
  assign bus.ir_pc     = ir_pc_q;
  assign bus.opcode    = instr_q[OP_HI:OP_LO];
  assign bus.rs        = instr_q[RS_HI:RS_LO];
  assign bus.rt        = instr_q[RT_HI:RT_LO];
  assign bus.rd        = instr_q[RD_HI:RD_LO];
  assign bus.shamt     = instr_q[SH_HI:SH_LO];
  assign bus.func      = instr_q[FN_HI:FN_LO];

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_q;
  logic [31:0] stall_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      if (valid_q && bus.ir_ready) begin
        fetch_q <= fetch_q + 32'd1;
      end
      if (req_q && !bus.imem_ack) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign fetch_cnt = fetch_q;
  assign stall_cnt = stall_q;
`endif

endmodule
